comp_event_monitor: RTL
=======================

// Module: comp_event_monitor
// PURPOSE
//  Downstream consumer of the 4-bit magnitude comparator's g/l/e flags.
//  Debounces the relation (a>b, a<b, a==b) over STABLE_CNT consecutive valid samples.
//  Tracks the settled relation in an FSM, pulses on every settled change, flags illegal
//  (non-one-hot) flag codes, and counts saturating "rise" events (entries into ABOVE).
// PARAMETERS
//  STABLE_CNT  3  consecutive identical legal valid samples needed to settle (1..15)
//  CNT_W       8  width of rise_cnt
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      g/l/e sample is valid this cycle
//  g          in   1      comparator a>b
//  l          in   1      comparator a<b
//  e          in   1      comparator a==b
//  clr_cnt    in   1      synchronous clear of rise_cnt
//  state      out  2      settled relation: 00 UNKNOWN, 01 BELOW, 10 EQUAL, 11 ABOVE
//  chg        out  1      1-cycle pulse: state changed
//  err        out  1      1-cycle pulse: illegal code sampled
//  rise_cnt   out  CNT_W  saturating count of entries into ABOVE
// BEHAVIOUR
//  - Reset: rst_n low at a clk edge -> state=UNKNOWN, chg=0, err=0, rise_cnt=0,
//    cand=UNKNOWN, run=0. Takes effect mid-run; any partial debounce is discarded.
//  - Code {g,l,e}: 100=ABOVE, 010=BELOW, 001=EQUAL; any other value is illegal.
//  - in_valid=0: cand/run/state are held (gaps do not break a run); chg=0, err=0.
//  - Valid illegal sample: err=1 next cycle; run<=0, cand<=UNKNOWN; state is held.
//  - Valid legal sample equal to cand: run<=min(run+1, STABLE_CNT).
//  - Valid legal sample differing from cand: cand<=code, run<=1.
//  - Settle: a sample that makes the new run==STABLE_CNT while cand!=state ->
//    state<=cand on the same edge; chg=1 for exactly that following cycle.
//    Latency is STABLE_CNT valid samples; state and chg are registered outputs.
//    With STABLE_CNT=1, the first legal sample settles immediately.
//  - Once settled, further identical samples: no chg (run saturated at STABLE_CNT).
//  - FSM transitions: UNKNOWN->{BELOW,EQUAL,ABOVE}; any settled->any other settled.
//    Returning to UNKNOWN happens only through reset.
//  - rise_cnt: increments when state settles to ABOVE from BELOW or EQUAL.
//    It does not increment from UNKNOWN. It saturates at 2^CNT_W-1 (no wrap).
//  - clr_cnt and an increment on the same edge -> rise_cnt=0 (clear wins).
//  - err and chg can never assert together from the same sample.
// STRUCTURE
//  - comp_mon_pkg: state encodings (ST_UNKNOWN/BELOW/EQUAL/ABOVE) and flag-code
//    constants (CODE_GT=3'b100, CODE_LT=3'b010, CODE_EQ=3'b001).
//  - Sub-module comp_debounce: cand/run register pair plus a "settled" strobe.
//  - Top level: state register, chg/err pulse flops, saturating rise counter.
// TESTING
//  1. STABLE_CNT=3; valid 100 x3 after reset -> chg once after 3rd sample; state=11;
//     rise_cnt=0 (from UNKNOWN).
//  2. Then 010 x3, then 100 x3 -> two chg pulses; state 01 then 11; rise_cnt=1.
//  3. 100,100,010,100,100,100 from BELOW -> run restarts at the 3rd sample; settles
//     to ABOVE only after the 6th sample.
//  4. Valid 110 mid-run -> err pulse next cycle; run restarts; state unchanged.
//     in_valid=0 gaps inside a run -> no restart.
//  5. CNT_W=2; force 4 rises -> rise_cnt stays 3.
//     clr_cnt coincident with a rise -> rise_cnt=0.
//  6. rst_n low for 1 cycle after 2 of 3 ABOVE samples -> state=UNKNOWN, no chg;
//     3 fresh samples are then needed to settle.

Source files
------------

// File: rtl/comp_mon_pkg.sv
// Shared encodings for the comparator event monitor: settled-relation states,
// comparator flag codes and the code decode helpers.
package comp_mon_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_BELOW   = 2'b01,
        ST_EQUAL   = 2'b10,
        ST_ABOVE   = 2'b11
    } state_e;

    // Flag codes are ordered {g, l, e}.
    localparam logic [2:0] CODE_GT = 3'b100;
    localparam logic [2:0] CODE_LT = 3'b010;
    localparam logic [2:0] CODE_EQ = 3'b001;

    // Run counter is wide enough for the largest debounce length (15).
    localparam int RUN_W = 4;

    function automatic logic code_legal(input logic [2:0] code);
        return (code == CODE_GT) || (code == CODE_LT) || (code == CODE_EQ);
    endfunction

    // Illegal codes map to UNKNOWN; callers gate on code_legal() first.
    function automatic state_e code_to_state(input logic [2:0] code);
        state_e s;
        case (code)
            CODE_GT: s = ST_ABOVE;
            CODE_LT: s = ST_BELOW;
            CODE_EQ: s = ST_EQUAL;
            default: s = ST_UNKNOWN;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/comp_event_monitor_if.sv
// Sample bus carrying the comparator flags and their valid qualifier.
interface comp_event_monitor_if;
    logic in_valid;
    logic g;
    logic l;
    logic e;

    modport master (output in_valid, g, l, e);
    modport slave  (input  in_valid, g, l, e);
endinterface

// File: rtl/comp_debounce.sv
// Candidate/run tracker: counts consecutive identical legal samples and strobes
// "settle" on the sample that completes a run for a relation not yet settled.
module comp_debounce
    import comp_mon_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] code,
    input  state_e     cur_state,
    output logic       settle,
    output state_e     settle_state,
    output logic       illegal
);

    localparam logic [RUN_W-1:0] STABLE_LIM = RUN_W'(STABLE_CNT);

    state_e           cand_q, cand_d;
    logic [RUN_W-1:0] run_q,  run_d;

    // Next candidate/run from the current sample; gaps hold everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        cand_d  = cand_q;
        run_d   = run_q;
        settle  = 1'b0;
        illegal = 1'b0;
        if (in_valid) begin
            if (!code_legal(code)) begin
                illegal = 1'b1;
                cand_d  = ST_UNKNOWN;
                run_d   = '0;
            end else if (code_to_state(code) == cand_q) begin
                if (run_q < STABLE_LIM) run_d = run_q + 1'b1;
            end else begin
                cand_d = code_to_state(code);
                run_d  = RUN_W'(1);
            end
            if (!illegal && (run_d == STABLE_LIM) && (cand_d != cur_state)) settle = 1'b1;
        end
    end

    assign settle_state = cand_d;

    // Candidate/run registers with synchronous reset discarding any partial run.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            cand_q <= ST_UNKNOWN;
            run_q  <= '0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/comp_event_monitor.sv
// Settled-relation monitor: debounced FSM state, change/error pulses and a
// saturating count of entries into ABOVE from another settled relation.
module comp_event_monitor
    import comp_mon_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comp_event_monitor_if.slave  bus,
    input  logic                 clr_cnt,
    output logic [1:0]           state,
    output logic                 chg,
    output logic                 err,
    output logic [CNT_W-1:0]     rise_cnt
);

    state_e           state_q, state_d;
    logic             chg_q,   chg_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] rise_q,  rise_d;

    logic   settle;
    logic   illegal;
    state_e settle_state;

    comp_debounce #(.STABLE_CNT(STABLE_CNT)) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (bus.in_valid),
        .code         ({bus.g, bus.l, bus.e}),
        .cur_state    (state_q),
        .settle       (settle),
        .settle_state (settle_state),
        .illegal      (illegal)
    );

    // State register plus pulse and counter flops, synchronously reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_UNKNOWN;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
            rise_q  <= '0;
        end else begin
            state_q <= state_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
            rise_q  <= rise_d;
        end
    end

    // Next state: move to the debounced candidate on settle; UNKNOWN only via reset.
    always_comb begin
        state_d = state_q;
        chg_d   = settle;
        err_d   = illegal;
        rise_d  = rise_q;
        if (settle) begin
            state_d = settle_state;
            if ((settle_state == ST_ABOVE) && (state_q != ST_UNKNOWN) && (rise_q != {CNT_W{1'b1}}))
                rise_d = rise_q + 1'b1;
        end
        if (clr_cnt) rise_d = '0;
    end

    // Outputs are straight from flops.
    always_comb begin
        state    = state_q;
        chg      = chg_q;
        err      = err_q;
        rise_cnt = rise_q;
    end

endmodule
